// File: rtl/cmd_desc_sequencer.sv
// cmd_desc_sequencer: fetches an 8-byte command descriptor from the regfile, decodes it
// and runs one of the SDR/HDR/CCC engines until it reports done, is aborted or times out.
module cmd_desc_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              i_sdr_clk,
  input  logic              i_sdr_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_regf_rd_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  input  logic [7:0]        i_regf_data_rd,
  output logic              o_sdr_en,
  output logic              o_hdr_en,
  output logic              o_ccc_en,
  input  logic              i_engine_done,
  output logic [2:0]        o_cmd_attr,
  output logic [3:0]        o_tid,
  output logic [7:0]        o_cmd,
  output logic              o_cp,
  output logic [4:0]        o_dev_index,
  output logic [2:0]        o_dtt,
  output logic [2:0]        o_mode,
  output logic              o_rnw,
  output logic              o_wroc,
  output logic              o_toc,
  output logic [7:0]        o_def_byte,
  output logic [23:0]       o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_err_code
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DISPATCH, DONE, ERROR} state_t;
  typedef enum logic [1:0] {ENG_NONE, ENG_SDR, ENG_HDR, ENG_CCC} engine_t;

  state_t            state, state_nxt;
  engine_t           engine, engine_nxt;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        fetch_cnt;
  logic [CNT_W-1:0]  disp_cnt;
  logic [7:0]        desc [8];
  logic [2:0]        cap_idx;
  logic              start_ok;
  logic              err_set;
  logic [2:0]        err_code_nxt;
  logic [2:0]        dec_attr;
  logic [2:0]        dec_mode;
  logic              dec_cp;
  logic              unused_rsvd;

  assign start_ok    = (state == IDLE) && i_start && !i_abort;
  assign cap_idx     = fetch_cnt[2:0] - 3'd1;
  assign dec_attr    = desc[0][2:0];
  assign dec_mode    = desc[3][4:2];
  assign dec_cp      = desc[1][7];
  assign unused_rsvd = ^desc[2][6:5];

  always_comb begin
    state_nxt    = state;
    engine_nxt   = engine;
    err_set      = 1'b0;
    err_code_nxt = 3'd0;
    case (state)
      IDLE: if (start_ok) state_nxt = FETCH;
      FETCH: begin
        if (i_abort) begin
          err_set      = 1'b1;
          err_code_nxt = 3'd3;
        end else if (fetch_cnt == 4'd8) begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        engine_nxt = ENG_NONE;
        if (i_abort) begin
          err_set      = 1'b1;
          err_code_nxt = 3'd3;
        end else if (dec_attr > 3'd1) begin
          err_set      = 1'b1;
          err_code_nxt = 3'd2;
        end else if (dec_mode == 3'd0) begin
          engine_nxt = ENG_SDR;
          state_nxt  = DISPATCH;
        end else if (dec_mode == 3'd6) begin
          engine_nxt = dec_cp ? ENG_CCC : ENG_HDR;
          state_nxt  = DISPATCH;
        end else begin
          err_set      = 1'b1;
          err_code_nxt = 3'd1;
        end
      end
      // Abort beats done, and done beats a timeout landing on the same cycle
      DISPATCH: begin
        if (i_abort) begin
          err_set      = 1'b1;
          err_code_nxt = 3'd3;
        end else if (i_engine_done) begin
          state_nxt = DONE;
        end else if (disp_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_set      = 1'b1;
          err_code_nxt = 3'd4;
        end
      end
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (err_set) state_nxt = ERROR;
  end

  always_ff @(posedge i_sdr_clk) begin
    if (!i_sdr_rst_n) begin
      state      <= IDLE;
      engine     <= ENG_NONE;
      base_addr  <= '0;
      fetch_cnt  <= '0;
      disp_cnt   <= '0;
      o_err_code <= '0;
    end else begin
      state     <= state_nxt;
      engine    <= engine_nxt;
      fetch_cnt <= (state == FETCH) ? fetch_cnt + 4'd1 : 4'd0;
      disp_cnt  <= (state == DISPATCH) ? disp_cnt + CNT_W'(1) : '0;
      if (start_ok) begin
        base_addr  <= i_base_addr;
        o_err_code <= '0;
      end else if (err_set) begin
        o_err_code <= err_code_nxt;
      end
    end
  end

  // Byte n arrives one cycle after its address, so the capture index lags fetch_cnt by one
  always_ff @(posedge i_sdr_clk) begin
    if (!i_sdr_rst_n) begin
      for (int i = 0; i < 8; i++) desc[i] <= '0;
      o_cmd_attr  <= '0;
      o_tid       <= '0;
      o_cmd       <= '0;
      o_cp        <= 1'b0;
      o_dev_index <= '0;
      o_dtt       <= '0;
      o_mode      <= '0;
      o_rnw       <= 1'b0;
      o_wroc      <= 1'b0;
      o_toc       <= 1'b0;
      o_def_byte  <= '0;
      o_data      <= '0;
    end else begin
      if (state == FETCH && fetch_cnt != 4'd0) desc[cap_idx] <= i_regf_data_rd;
      if (state == DECODE) begin
        o_cmd_attr  <= desc[0][2:0];
        o_tid       <= desc[0][6:3];
        o_cmd       <= {desc[1][6:0], desc[0][7]};
        o_cp        <= desc[1][7];
        o_dev_index <= desc[2][4:0];
        o_dtt       <= {desc[3][1:0], desc[2][7]};
        o_mode      <= desc[3][4:2];
        o_rnw       <= desc[3][5];
        o_wroc      <= desc[3][6];
        o_toc       <= desc[3][7];
        o_def_byte  <= desc[4];
        o_data      <= {desc[7], desc[6], desc[5]};
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign o_err        = (state == ERROR);
  assign o_regf_rd_en = (state == FETCH) && !fetch_cnt[3];
  assign o_regf_addr  = o_regf_rd_en ? base_addr + ADDR_W'(fetch_cnt) : '0;
  assign o_sdr_en     = (state == DISPATCH) && (engine == ENG_SDR);
  assign o_hdr_en     = (state == DISPATCH) && (engine == ENG_HDR);
  assign o_ccc_en     = (state == DISPATCH) && (engine == ENG_CCC);

endmodule

// File: tb/tb_cmd_desc_sequencer.sv
// tb_cmd_desc_sequencer: directed and randomized descriptor commands checked cycle by
// cycle against a timeline model derived from the descriptor rules.
`timescale 1ns/1ps
module tb_cmd_desc_sequencer;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;
  localparam int MEM_SZ  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              engine_done = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              regf_rd_en;
  logic [ADDR_W-1:0] regf_addr;
  logic [7:0]        regf_data = '0;
  logic              sdr_en, hdr_en, ccc_en;
  logic [2:0]        cmd_attr, dtt, mode, err_code;
  logic [3:0]        tid;
  logic [7:0]        cmd, def_byte;
  logic              cp, rnw, wroc, toc;
  logic [4:0]        dev_index;
  logic [23:0]       data;
  logic              busy, done, err;
  logic [63:0]       dut_fields;
  logic [7:0]        mem [MEM_SZ];
  logic [63:0]       prev_fields = '0;
  int                checks = 0;
  int                errors = 0;

  cmd_desc_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .i_sdr_clk(clk), .i_sdr_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_base_addr(base_addr), .o_regf_rd_en(regf_rd_en), .o_regf_addr(regf_addr),
    .i_regf_data_rd(regf_data), .o_sdr_en(sdr_en), .o_hdr_en(hdr_en), .o_ccc_en(ccc_en),
    .i_engine_done(engine_done), .o_cmd_attr(cmd_attr), .o_tid(tid), .o_cmd(cmd),
    .o_cp(cp), .o_dev_index(dev_index), .o_dtt(dtt), .o_mode(mode), .o_rnw(rnw),
    .o_wroc(wroc), .o_toc(toc), .o_def_byte(def_byte), .o_data(data), .o_busy(busy),
    .o_done(done), .o_err(err), .o_err_code(err_code)
  );

  assign dut_fields = {2'b00, cmd_attr, tid, cmd, cp, dev_index, dtt, mode,
                       rnw, wroc, toc, def_byte, data};

  always #5 clk = ~clk;

  // Regfile: one-cycle read latency, garbage on the bus when not reading
  always @(posedge clk) regf_data <= regf_rd_en ? mem[regf_addr] : 8'($urandom);

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] field_model(input logic [7:0][7:0] b);
    int attr, tid_v, cmd_v, cp_v, dev, dtt_v, mode_v, rnw_v, wroc_v, toc_v, data_v;
    attr   = b[0] % 8;
    tid_v  = (b[0] / 8) % 16;
    cmd_v  = (b[1] % 128) * 2 + b[0] / 128;
    cp_v   = b[1] / 128;
    dev    = b[2] % 32;
    dtt_v  = (b[3] % 4) * 2 + b[2] / 128;
    mode_v = (b[3] / 4) % 8;
    rnw_v  = (b[3] / 32) % 2;
    wroc_v = (b[3] / 64) % 2;
    toc_v  = b[3] / 128;
    data_v = b[7] * 65536 + b[6] * 256 + b[5];
    return {2'b00, 3'(attr), 4'(tid_v), 8'(cmd_v), 1'(cp_v), 5'(dev), 3'(dtt_v),
            3'(mode_v), 1'(rnw_v), 1'(wroc_v), 1'(toc_v), b[4], 24'(data_v)};
  endfunction

  // engine: 0 none, 1 SDR, 2 HDR, 3 CCC; code: nonzero means a decode error
  function automatic void classify(input logic [7:0][7:0] b, output int engine, output int code);
    int attr, mode_v, cp_v;
    attr   = b[0] % 8;
    mode_v = (b[3] / 4) % 8;
    cp_v   = b[1] / 128;
    engine = 0;
    code   = 0;
    if (attr > 1) code = 2;
    else if (mode_v == 0) engine = 1;
    else if (mode_v == 6) engine = (cp_v == 1) ? 3 : 2;
    else code = 1;
  endfunction

  // d: dispatch cycle in which engine_done is raised; ta: cycle of abort (0 = none)
  task automatic applyStimulus(input string name, input int base, input logic [7:0][7:0] b,
                               input int d, input int ta, input bit noise);
    int engine, code, nf, ncode, final_t, fcode, exp_addr;
    bit nerr, ferr, decoded, exp_rd;
    logic [63:0] new_fields;
    logic [2:0]  exp_en;
    for (int i = 0; i < 8; i++) mem[(base + i) % MEM_SZ] = b[i];
    classify(b, engine, code);
    new_fields = field_model(b);
    if (code != 0) begin nf = 11; nerr = 1'b1; ncode = code; end
    else if (d < TIMEOUT) begin nf = 12 + d; nerr = 1'b0; ncode = 0; end
    else begin nf = 11 + TIMEOUT; nerr = 1'b1; ncode = 4; end
    if (ta >= 1 && ta < nf) begin final_t = ta + 1; ferr = 1'b1; fcode = 3; end
    else begin final_t = nf; ferr = nerr; fcode = ncode; end
    decoded = (final_t >= 11);
    case (engine)
      1:       exp_en = 3'b100;
      2:       exp_en = 3'b010;
      3:       exp_en = 3'b001;
      default: exp_en = 3'b000;
    endcase
    @(negedge clk);
    start = 1'b1; abort = 1'b0; engine_done = 1'b0;
    base_addr = ADDR_W'(base);
    for (int t = 1; t <= final_t + 1; t++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; engine_done = 1'b0;
      exp_rd   = (t <= 8) && (t < final_t);
      exp_addr = exp_rd ? (base + t - 1) % MEM_SZ : 0;
      checkOutput({name, " busy"}, 64'(busy), 64'(t <= final_t));
      checkOutput({name, " rd_en"}, 64'(regf_rd_en), 64'(exp_rd));
      checkOutput({name, " addr"}, 64'(regf_addr), 64'(exp_addr));
      checkOutput({name, " enables"}, 64'({sdr_en, hdr_en, ccc_en}),
                  64'((t >= 11 && t < final_t && engine != 0) ? exp_en : 3'b000));
      checkOutput({name, " done"}, 64'(done), 64'(t == final_t && !ferr));
      checkOutput({name, " err"}, 64'(err), 64'(t == final_t && ferr));
      checkOutput({name, " err_code"}, 64'(err_code), 64'((t >= final_t && ferr) ? fcode : 0));
      checkOutput({name, " fields"}, dut_fields, (decoded && t >= 11) ? new_fields : prev_fields);
      if (t == ta) abort = 1'b1;
      if (engine != 0 && t == 11 + d) engine_done = 1'b1;
      if (noise && t <= final_t) begin
        start = 1'($urandom_range(0, 1));
        if (t <= 10 || t == final_t) engine_done = engine_done | 1'($urandom_range(0, 1));
      end
    end
    if (decoded) prev_fields = new_fields;
  endtask

  task automatic resetMidCommand(input string name, input int t_rst, input bit in_fetch);
    logic [7:0][7:0] b;
    b = {8'h04, 8'h03, 8'h02, 8'h01, 8'hC1, 8'h23, 8'h80, 8'h19};
    for (int i = 0; i < 8; i++) mem[300 + i] = b[i];
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(300);
    for (int t = 1; t <= t_rst; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (in_fetch) checkOutput({name, " active"}, 64'(regf_rd_en), 64'd1);
    else checkOutput({name, " active"}, 64'({sdr_en, hdr_en, ccc_en}), 64'(3'b100));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput({name, " rd_en"}, 64'(regf_rd_en), 64'd0);
    checkOutput({name, " enables"}, 64'({sdr_en, hdr_en, ccc_en}), 64'd0);
    checkOutput({name, " pulses"}, 64'({done, err}), 64'd0);
    checkOutput({name, " busy"}, 64'(busy), 64'd0);
    checkOutput({name, " fields"}, dut_fields, 64'd0);
    rst_n = 1'b1;
    prev_fields = '0;
    @(negedge clk);
    checkOutput({name, " idle"}, 64'({busy, done, err}), 64'd0);
  endtask

  initial begin
    logic [7:0][7:0] b;
    int d, ta, base;
    for (int i = 0; i < MEM_SZ; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset rd_en", 64'(regf_rd_en), 64'd0);
    checkOutput("reset addr", 64'(regf_addr), 64'd0);
    checkOutput("reset enables", 64'({sdr_en, hdr_en, ccc_en}), 64'd0);
    checkOutput("reset pulses", 64'({done, err}), 64'd0);
    checkOutput("reset err_code", 64'(err_code), 64'd0);
    checkOutput("reset fields", dut_fields, 64'd0);
    rst_n = 1'b1;

    b = {8'h04, 8'h03, 8'h02, 8'h01, 8'hD9, 8'h23, 8'h80, 8'h19};
    applyStimulus("ccc", 1000, b, 3, 0, 1'b0);
    b[1] = 8'hC0;
    applyStimulus("direct_ccc", 1000, b, 0, 0, 1'b0);
    b[3] = 8'hCD;
    applyStimulus("bad_mode", 1500, b, 0, 0, 1'b0);
    b[3] = 8'hD9; b[0] = 8'h1D;
    applyStimulus("bad_attr", 1500, b, 0, 0, 1'b0);
    b[3] = 8'hCD;
    applyStimulus("bad_both", 1500, b, 0, 0, 1'b0);
    b[3] = 8'hD9; b[0] = 8'h19;
    applyStimulus("abort_dispatch", 200, b, 10, 13, 1'b0);

    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = ADDR_W'(7);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("idle_abort busy", 64'(busy), 64'd0);
    checkOutput("idle_abort err_code", 64'(err_code), 64'd3);

    applyStimulus("abort_fetch", 50, b, 2, 4, 1'b0);
    applyStimulus("abort_decode", 60, b, 2, 10, 1'b0);
    applyStimulus("abort_vs_done", 70, b, 2, 13, 1'b0);
    applyStimulus("timeout", 80, b, 20, 0, 1'b0);
    applyStimulus("done_at_timeout", 90, b, 15, 0, 1'b0);
    b[1] = 8'h00;
    applyStimulus("hdr", 100, b, 1, 0, 1'b0);
    b[3] = 8'hC1;
    applyStimulus("wrap_sdr", 4094, b, 1, 0, 1'b0);

    resetMidCommand("rst_fetch", 5, 1'b1);
    resetMidCommand("rst_dispatch", 13, 1'b0);

    for (int n = 0; n < 40; n++) begin
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) b[0][2:0] = 3'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) b[3][4:2] = ($urandom_range(0, 1) == 1) ? 3'd6 : 3'd0;
      d    = $urandom_range(0, 20);
      ta   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      base = $urandom_range(0, MEM_SZ - 1);
      applyStimulus("random", base, b, d, ta, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
